// File: rtl/task_icd_pkg.sv
// ============================================================================
// Module   : task_icd_pkg
// Brief    : Task ICD constants, message types and header helper functions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package task_icd_pkg;

  localparam int MAX_MSG_WORDS      = 12;
  localparam int HEADER_WORDS       = 4;
  localparam int HEADER_BYTES       = HEADER_WORDS * 4;
  localparam int MAX_MSG_BYTES      = MAX_MSG_WORDS * 4;
  localparam int BANK_PAYLOAD_WORDS = 8;
  localparam int OUT_PAYLOAD_WORDS  = 1;

  typedef logic [31:0] msg_word_t;
  typedef msg_word_t msg_arr_t [MAX_MSG_WORDS];

  typedef enum logic [31:0] {
    TASK_VALID      = 32'd0,
    HEADER_INVALID  = 32'd1,
    PAYLOAD_INVALID = 32'd2
  } status_t;

  typedef enum logic [31:0] {
    TASK_ID_BANK = 32'd100,
    TASK_ID_OUT  = 32'd101
  } task_id_t;

  typedef enum logic [1:0] {
    RX_HDR = 2'd0,
    RX_PAY = 2'd1,
    OUT    = 2'd2
  } rx_state_t;

  // LEN is a byte count: word aligned, at least a header, at most a full buffer.
  function automatic logic len_valid(input msg_word_t len);
    return (len[1:0] == 2'b00) &&
           (len >= 32'(HEADER_BYTES)) &&
           (len <= 32'(MAX_MSG_BYTES));
  endfunction

  function automatic logic task_id_known(input msg_word_t id);
    return (id == 32'(TASK_ID_BANK)) || (id == 32'(TASK_ID_OUT));
  endfunction

endpackage

`default_nettype wire

// File: rtl/task_hdr_check.sv
// ============================================================================
// Module   : task_hdr_check
// Brief    : Combinational header/payload-length verdict for a task message.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module task_hdr_check
  import task_icd_pkg::*;
(
  input  msg_word_t  hdr [HEADER_WORDS],
  input  logic [3:0] rcv_words,
  output status_t    status
);

  logic [3:0] w_pay_words;

  always_comb begin
    status      = TASK_VALID;
    w_pay_words = rcv_words - 4'(HEADER_WORDS);
    if (!len_valid(hdr[0]) || (hdr[3] != 32'(TASK_VALID)) || !task_id_known(hdr[2])) begin
      status = HEADER_INVALID;
    end else if (((hdr[2] == 32'(TASK_ID_BANK)) && (w_pay_words != 4'(BANK_PAYLOAD_WORDS))) ||
                 ((hdr[2] == 32'(TASK_ID_OUT))  && (w_pay_words != 4'(OUT_PAYLOAD_WORDS)))) begin
      status = PAYLOAD_INVALID;
    end
  end

endmodule

`default_nettype wire

// File: rtl/task_msg_rx.sv
// ============================================================================
// Module   : task_msg_rx
// Brief    : Assembles link words into one buffered task message with verdict.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module task_msg_rx
  import task_icd_pkg::*;
#(
  parameter int MAX_WORDS = MAX_MSG_WORDS,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [31:0]             s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [MAX_WORDS*32-1:0] m_words,
  output logic [3:0]              m_len_words,
  output logic [31:0]             m_status,
  output logic [CNT_W-1:0]        msg_cnt,
  output logic [CNT_W-1:0]        err_cnt
);

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  msg_word_t        r_buf [MAX_WORDS];
  logic [3:0]       r_idx;
  status_t          r_status;
  logic [3:0]       r_len_words;
  logic [CNT_W-1:0] r_msg_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  msg_word_t        w_hdr [HEADER_WORDS];
  logic             w_accept;
  logic             w_consume;
  logic             w_len_ok;
  logic             w_last;
  logic [3:0]       w_exp_words;
  logic [3:0]       w_rcv_words;
  status_t          w_status;

  assign s_ready     = rst_n && (r_state != OUT);
  assign w_accept    = s_valid && s_ready;
  assign w_consume   = (r_state == OUT) && m_ready;
  assign w_len_ok    = len_valid(r_buf[0]);
  assign w_exp_words = r_buf[0][5:2];
  assign w_rcv_words = r_idx + 4'd1;

  // The STATUS word is still on s_data when the header closes in RX_HDR.
  always_comb begin
    w_hdr[0] = r_buf[0];
    w_hdr[1] = r_buf[1];
    w_hdr[2] = r_buf[2];
    w_hdr[3] = (r_state == RX_HDR) ? s_data : r_buf[3];
  end

  task_hdr_check u_hdr_check (
    .hdr       (w_hdr),
    .rcv_words (w_rcv_words),
    .status    (w_status)
  );

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      RX_HDR:  w_last = (r_idx == 4'd3) && (!w_len_ok || (w_exp_words == 4'(HEADER_WORDS)));
      RX_PAY:  w_last = (r_idx == (w_exp_words - 4'd1));
      default: w_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_HDR: begin
        if (w_accept && (r_idx == 4'd3)) begin
          w_state_nxt = w_last ? OUT : RX_PAY;
        end
      end
      RX_PAY: begin
        if (w_accept && w_last) begin
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        if (m_ready) begin
          w_state_nxt = RX_HDR;
        end
      end
      default: w_state_nxt = RX_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        r_buf[i] <= '0;
      end
      r_idx       <= '0;
      r_status    <= TASK_VALID;
      r_len_words <= '0;
      r_msg_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_buf[r_idx] <= s_data;
        if (w_last) begin
          r_idx       <= '0;
          r_status    <= w_status;
          r_len_words <= w_rcv_words;
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
      // Clearing on consume keeps unused slots of the next message at zero.
      if (w_consume) begin
        for (int i = 0; i < MAX_WORDS; i++) begin
          r_buf[i] <= '0;
        end
        r_status    <= TASK_VALID;
        r_len_words <= '0;
        if (r_msg_cnt != '1) begin
          r_msg_cnt <= r_msg_cnt + CNT_W'(1);
        end
        if ((r_status != TASK_VALID) && (r_err_cnt != '1)) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_words
      assign m_words[32*gi +: 32] = r_buf[gi];
    end
  endgenerate

  assign m_valid     = (r_state == OUT);
  assign m_len_words = r_len_words;
  assign m_status    = r_status;
  assign msg_cnt     = r_msg_cnt;
  assign err_cnt     = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_task_msg_rx.sv
// ============================================================================
// Module   : tb_task_msg_rx
// Brief    : Directed self-checking bench for task_msg_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_task_msg_rx
  import task_icd_pkg::*;
;

  localparam int W = MAX_MSG_WORDS * 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic [31:0]  s_data = '0;
  logic         m_ready = 1'b0;

  logic         s_ready, m_valid;
  logic [W-1:0] m_words;
  logic [3:0]   m_len_words;
  logic [31:0]  m_status;
  logic [15:0]  msg_cnt, err_cnt;

  logic         sat_s_ready, sat_m_valid;
  logic [W-1:0] sat_m_words;
  logic [3:0]   sat_m_len_words;
  logic [31:0]  sat_m_status;
  logic [1:0]   sat_msg_cnt, sat_err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task_msg_rx dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_words(m_words), .m_len_words(m_len_words),
    .m_status(m_status), .msg_cnt(msg_cnt), .err_cnt(err_cnt)
  );

  task_msg_rx #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sat_s_ready), .s_data(s_data),
    .m_valid(sat_m_valid), .m_ready(m_ready), .m_words(sat_m_words),
    .m_len_words(sat_m_len_words), .m_status(sat_m_status),
    .msg_cnt(sat_msg_cnt), .err_cnt(sat_err_cnt)
  );

  function automatic msg_arr_t mk_hdr(input logic [31:0] len, input logic [31:0] seq,
                                      input logic [31:0] tid, input logic [31:0] st);
    msg_arr_t m;
    m = '{default: '0};
    m[0] = len; m[1] = seq; m[2] = tid; m[3] = st;
    return m;
  endfunction

  function automatic logic [W-1:0] pack_exp(input msg_arr_t m, input int n);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[32*i +: 32] = m[i];
    return v;
  endfunction

  task automatic send_word(input logic [31:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!s_ready) begin
      $display("FAIL send_word_ready: s_ready=%0b after %0d cycles, required 1", s_ready, waited);
      errors++;
    end
    @(posedge clk);
  endtask

  // Returns #1 after the last word's handshake edge with s_valid dropped.
  task automatic send_msg(input msg_arr_t m, input int n);
    for (int i = 0; i < n; i++) send_word(m[i]);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) begin $display("FAIL reset_s_ready: got %0b want 0", s_ready); errors++; end
    checks++; if (m_valid !== 1'b0) begin $display("FAIL reset_m_valid: got %0b want 0", m_valid); errors++; end
    checks++; if (m_words !== '0) begin $display("FAIL reset_m_words: got %h want 0", m_words); errors++; end
    checks++; if ({m_len_words, m_status, msg_cnt, err_cnt} !== '0) begin
      $display("FAIL reset_regs: len=%0d status=%0d msg=%0d err=%0d want all 0",
               m_len_words, m_status, msg_cnt, err_cnt); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin $display("FAIL reset_release_s_ready: got %0b want 1", s_ready); errors++; end
  endtask

  task automatic test_valid_out();
    msg_arr_t m;
    m = mk_hdr(32'd20, 32'd7, 32'd101, 32'd0);
    m[4] = 32'hDEADBEEF;
    send_msg(m, 5);
    checks++; if (m_valid !== 1'b1) begin $display("FAIL out_m_valid: got %0b want 1", m_valid); errors++; end
    checks++; if (m_len_words !== 4'd5) begin $display("FAIL out_len: got %0d want 5", m_len_words); errors++; end
    checks++; if (m_status !== 32'(TASK_VALID)) begin $display("FAIL out_status: got %0d want %0d", m_status, TASK_VALID); errors++; end
    checks++; if (m_words !== pack_exp(m, 5)) begin $display("FAIL out_words: got %h want %h", m_words, pack_exp(m, 5)); errors++; end
    checks++; if (s_ready !== 1'b0) begin $display("FAIL out_s_ready: got %0b want 0", s_ready); errors++; end
    consume();
    checks++; if (msg_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      $display("FAIL out_counters: msg=%0d err=%0d want 1/0", msg_cnt, err_cnt); errors++; end
    checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      $display("FAIL out_release: s_ready=%0b m_valid=%0b want 1/0", s_ready, m_valid); errors++; end
  endtask

  task automatic test_back_to_back_stall();
    msg_arr_t m;
    m = mk_hdr(32'd48, 32'd8, 32'd100, 32'd0);
    for (int i = 4; i < 12; i++) m[i] = 32'hB000_0000 + 32'(i);
    send_msg(m, 12);
    checks++; if (m_len_words !== 4'd12 || m_status !== 32'(TASK_VALID)) begin
      $display("FAIL bank_verdict: len=%0d status=%0d want 12/0", m_len_words, m_status); errors++; end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
        $display("FAIL bank_stall_hs cycle %0d: m_valid=%0b s_ready=%0b want 1/0", c, m_valid, s_ready); errors++; end
      checks++; if (m_words !== pack_exp(m, 12) || m_len_words !== 4'd12) begin
        $display("FAIL bank_stall_data cycle %0d: got %h len %0d want %h len 12", c, m_words, m_len_words, pack_exp(m, 12)); errors++; end
    end
    consume();
    checks++; if (s_ready !== 1'b1 || msg_cnt !== 16'd2) begin
      $display("FAIL bank_release: s_ready=%0b msg=%0d want 1/2", s_ready, msg_cnt); errors++; end
  endtask

  task automatic test_bad_len();
    msg_arr_t m;
    m = mk_hdr(32'd18, 32'd1, 32'd101, 32'd0);
    send_msg(m, 4);
    checks++; if (m_valid !== 1'b1 || m_status !== 32'(HEADER_INVALID) || m_len_words !== 4'd4) begin
      $display("FAIL badlen_verdict: valid=%0b status=%0d len=%0d want 1/%0d/4", m_valid, m_status, m_len_words, HEADER_INVALID); errors++; end
    checks++; if (m_words !== pack_exp(m, 4)) begin $display("FAIL badlen_words: got %h want %h", m_words, pack_exp(m, 4)); errors++; end
    consume();
    checks++; if (msg_cnt !== 16'd3 || err_cnt !== 16'd1) begin
      $display("FAIL badlen_counters: msg=%0d err=%0d want 3/1", msg_cnt, err_cnt); errors++; end
    m = mk_hdr(32'd20, 32'd2, 32'd101, 32'd0);
    m[4] = 32'h1234_5678;
    send_msg(m, 5);
    checks++; if (m_status !== 32'(TASK_VALID) || m_len_words !== 4'd5 || m_words !== pack_exp(m, 5)) begin
      $display("FAIL badlen_next: status=%0d len=%0d words=%h want 0/5/%h", m_status, m_len_words, m_words, pack_exp(m, 5)); errors++; end
    consume();
  endtask

  task automatic test_unknown_task();
    msg_arr_t m;
    m = mk_hdr(32'd24, 32'd3, 32'd55, 32'd0);
    m[4] = 32'hAAAA_0004;
    m[5] = 32'hAAAA_0005;
    send_msg(m, 4);
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      $display("FAIL unk_midframe: m_valid=%0b s_ready=%0b want 0/1", m_valid, s_ready); errors++; end
    send_word(m[4]);
    send_word(m[5]);
    #1;
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_status !== 32'(HEADER_INVALID) || m_len_words !== 4'd6) begin
      $display("FAIL unk_verdict: valid=%0b status=%0d len=%0d want 1/%0d/6", m_valid, m_status, m_len_words, HEADER_INVALID); errors++; end
    consume();
    checks++; if (err_cnt !== 16'd2 || msg_cnt !== 16'd5) begin
      $display("FAIL unk_counters: msg=%0d err=%0d want 5/2", msg_cnt, err_cnt); errors++; end
    m = mk_hdr(32'd20, 32'd4, 32'd101, 32'd0);
    m[4] = 32'h0BAD_F00D;
    send_msg(m, 5);
    checks++; if (m_status !== 32'(TASK_VALID) || m_len_words !== 4'd5 || m_words !== pack_exp(m, 5)) begin
      $display("FAIL unk_framing: status=%0d len=%0d words=%h want 0/5/%h", m_status, m_len_words, m_words, pack_exp(m, 5)); errors++; end
    consume();
  endtask

  task automatic test_payload_invalid();
    msg_arr_t m;
    m = mk_hdr(32'd24, 32'd5, 32'd101, 32'd0);
    m[4] = 32'hC0DE_0001;
    m[5] = 32'hC0DE_0002;
    send_msg(m, 6);
    checks++; if (m_status !== 32'(PAYLOAD_INVALID) || m_len_words !== 4'd6) begin
      $display("FAIL pay_verdict: status=%0d len=%0d want %0d/6", m_status, m_len_words, PAYLOAD_INVALID); errors++; end
    checks++; if (m_words[W-1:192] !== '0) begin $display("FAIL pay_unused: got %h want 0", m_words[W-1:192]); errors++; end
    checks++; if (m_words !== pack_exp(m, 6)) begin $display("FAIL pay_words: got %h want %h", m_words, pack_exp(m, 6)); errors++; end
    consume();
    checks++; if (msg_cnt !== 16'd7 || err_cnt !== 16'd3) begin
      $display("FAIL pay_counters: msg=%0d err=%0d want 7/3", msg_cnt, err_cnt); errors++; end
  endtask

  task automatic test_mid_reset();
    msg_arr_t m;
    m = mk_hdr(32'd20, 32'd6, 32'd101, 32'd0);
    m[4] = 32'h5555_AAAA;
    send_msg(m, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0 || msg_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      $display("FAIL midrst_state: valid=%0b ready=%0b msg=%0d err=%0d want 0/0/0/0", m_valid, s_ready, msg_cnt, err_cnt); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (m_valid !== 1'b0 || m_words !== '0) begin
      $display("FAIL midrst_no_output: valid=%0b words=%h want 0/0", m_valid, m_words); errors++; end
    send_msg(m, 5);
    checks++; if (m_status !== 32'(TASK_VALID) || m_len_words !== 4'd5 || m_words !== pack_exp(m, 5)) begin
      $display("FAIL midrst_next: status=%0d len=%0d words=%h want 0/5/%h", m_status, m_len_words, m_words, pack_exp(m, 5)); errors++; end
    consume();
    checks++; if (msg_cnt !== 16'd1) begin $display("FAIL midrst_count: msg=%0d want 1", msg_cnt); errors++; end
  endtask

  task automatic test_saturation();
    msg_arr_t m;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m = mk_hdr(32'd20, 32'd9, 32'd101, 32'd0);
    m[4] = 32'h0000_0042;
    send_msg(m, 5);
    consume();
    m = mk_hdr(32'd50, 32'd10, 32'd100, 32'd0);
    for (int k = 0; k < 4; k++) begin
      send_msg(m, 4);
      consume();
    end
    checks++; if (msg_cnt !== 16'd5 || err_cnt !== 16'd4) begin
      $display("FAIL sat_wide: msg=%0d err=%0d want 5/4", msg_cnt, err_cnt); errors++; end
    checks++; if (sat_msg_cnt !== 2'd3) begin $display("FAIL sat_msg: got %0d want 3", sat_msg_cnt); errors++; end
    checks++; if (sat_err_cnt !== 2'd3) begin $display("FAIL sat_err: got %0d want 3", sat_err_cnt); errors++; end
  endtask

  initial begin
    test_reset();
    test_valid_out();
    test_back_to_back_stall();
    test_bad_len();
    test_unknown_task();
    test_payload_invalid();
    test_mid_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
